// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins by default; IF is guaranteed a grant after MAX_D_STREAK data grants.
module pipeline_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              if_stall_o,
  output logic              dm_stall_o
);

  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic                streak_full;

  assign streak_full = (streak_q == STREAK_W'(MAX_D_STREAK));

  // Next-state, grant and capture logic
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_req_i && !(if_req_i && streak_full)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          if (!if_req_i) begin
            streak_d = '0;
          end else if (!streak_full) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (if_req_i) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      BUSY_I: begin
        if (mem_ack_i) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata_i;
          if_ready_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack_i) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          dm_rdata_d = mem_rdata_i;
          dm_ready_d = 1'b1;
        end
      end
      RESP: begin
        // Requests are deliberately not sampled here
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign dm_ready_o  = dm_ready_q;

  assign if_stall_o  = if_req_i & ~if_ready_q;
  assign dm_stall_o  = dm_req_i & ~dm_ready_q;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Bench for pipeline_mem_arbiter: transaction-level reference model, directed
// scenarios with literal expectations, then a randomized soak with a memory responder.
module tb_pipeline_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXD = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [DW-1:0] if_rdata_o, dm_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          if_ready_o, dm_ready_o, mem_req_o, mem_we_o, if_stall_o, dm_stall_o;

  always #5 clk = ~clk;

  pipeline_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXD)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .if_stall_o(if_stall_o), .dm_stall_o(dm_stall_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one outstanding transfer, then one response cycle
  bit            m_busy, m_is_d, m_we, m_resp_i, m_resp_d;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata;
  int            m_run, m_wait, m_lat;
  string         glog;

  bit            rnd_mode, lat_rand, spur, force_ack, stall_flag;
  int            ack_lat, if_left, dm_left;
  logic [DW-1:0] rd_val;
  int            cyc, ack_cyc, dm_rdy_cyc, if_pulses, dm_pulses, stable_cnt, req_cycles;
  logic [AW-1:0] last_req_addr;
  logic          last_req_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_str(input string nm, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %s expected %s", nm, act, exp);
    end
  endtask

  // Requester behaviour: hold until ready, then drop or re-issue
  task automatic drive();
    if (rnd_mode) rd_val = $urandom;
    if (m_resp_i) begin
      if (rnd_mode) if_req = 1'($urandom_range(0, 1));
      else begin
        if (if_left > 0) if_left--;
        if_req = (if_left > 0);
      end
      if (rnd_mode && if_req) if_addr = $urandom;
    end else if (rnd_mode && !if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1'b1; if_addr = $urandom;
    end
    if (m_resp_d) begin
      if (rnd_mode) dm_req = 1'($urandom_range(0, 1));
      else begin
        if (dm_left > 0) dm_left--;
        dm_req = (dm_left > 0);
      end
      if (rnd_mode && dm_req) begin
        dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
      end
    end else if (rnd_mode && !dm_req && $urandom_range(0, 2) == 0) begin
      dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
    end
  endtask

  task automatic cycle();
    mem_ack = 1'b0;
    if (force_ack) begin
      mem_ack = 1'b1; mem_rdata = rd_val; force_ack = 1'b0;
    end else if (m_busy && m_wait == m_lat) begin
      mem_ack = 1'b1; mem_rdata = rd_val;
    end else if (!m_busy && spur && $urandom_range(0, 3) == 0) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
    end
    if (mem_ack) ack_cyc = cyc;
    #1;
    chk("if_stall", 32'(if_stall_o), 32'(if_req & ~m_resp_i));
    chk("dm_stall", 32'(dm_stall_o), 32'(dm_req & ~m_resp_d));

    if (rst) begin
      m_busy = 0; m_resp_i = 0; m_resp_d = 0; m_run = 0; m_if_rdata = '0; m_dm_rdata = '0;
    end else if (m_resp_i || m_resp_d) begin
      m_resp_i = 0; m_resp_d = 0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0;
        if (m_is_d) begin m_dm_rdata = mem_rdata; m_resp_d = 1; end
        else begin m_if_rdata = mem_rdata; m_resp_i = 1; end
      end else m_wait++;
    end else if (dm_req && !(if_req && m_run >= int'(MAXD))) begin
      m_busy = 1; m_is_d = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
      m_wait = 0; m_lat = lat_rand ? int'($urandom_range(0, 3)) : ack_lat;
      m_run = if_req ? m_run + 1 : 0;
      glog = {glog, "D"};
    end else if (if_req) begin
      m_busy = 1; m_is_d = 0; m_we = 0; m_addr = if_addr; m_wdata = '0;
      m_wait = 0; m_lat = lat_rand ? int'($urandom_range(0, 3)) : ack_lat;
      m_run = 0;
      glog = {glog, "I"};
    end

    @(posedge clk);
    #1;
    cyc++;
    chk("mem_req", 32'(mem_req_o), 32'(m_busy));
    if (m_busy) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_we", 32'(mem_we_o), 32'(m_we));
      if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
    end
    chk("if_ready", 32'(if_ready_o), 32'(m_resp_i));
    chk("dm_ready", 32'(dm_ready_o), 32'(m_resp_d));
    chk("if_rdata", if_rdata_o, m_if_rdata);
    chk("dm_rdata", dm_rdata_o, m_dm_rdata);
    if (if_ready_o) if_pulses++;
    if (dm_ready_o) begin dm_pulses++; dm_rdy_cyc = cyc; end
    if (dm_ready_o && if_stall_o) stall_flag = 1'b1;
    if (mem_req_o) begin req_cycles++; last_req_addr = mem_addr_o; last_req_we = mem_we_o; end
    if (mem_req_o && mem_addr_o == 32'h200 && mem_we_o && mem_wdata_o == 32'hDEADBEEF)
      stable_cnt++;
  endtask

  task automatic run_until_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (1) begin
      drive();
      cycle();
      n++;
      if (if_left == 0 && dm_left == 0 && !m_busy && !m_resp_i && !m_resp_d) break;
      if (n >= budget) break;
    end
    chk({nm, "_timeout"}, 32'(n >= budget), 32'd0);
  endtask

  task automatic clr_counts();
    if_pulses = 0; dm_pulses = 0; stable_cnt = 0; req_cycles = 0; stall_flag = 0; glog = "";
  endtask

  initial begin
    rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0; rd_val = '0;
    rnd_mode = 0; lat_rand = 0; spur = 0; force_ack = 0; ack_lat = 0;
    if_left = 0; dm_left = 0; cyc = 0; ack_cyc = 0; dm_rdy_cyc = 0;
    m_busy = 0; m_is_d = 0; m_we = 0; m_resp_i = 0; m_resp_d = 0; m_run = 0;
    m_wait = 0; m_lat = 0; m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
    last_req_addr = '0; last_req_we = 0;
    clr_counts();

    // Reset, then quiet idle
    repeat (5) cycle();
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_dm_ready", 32'(dm_ready_o), 32'd0);
    rst = 1'b0;
    repeat (3) cycle();
    chk("idle_mem_req", 32'(mem_req_o), 32'd0);

    // Single fetch, ack one cycle after mem_req
    clr_counts();
    ack_lat = 1; rd_val = 32'h00500093;
    if_addr = 32'h40; if_req = 1; if_left = 1;
    run_until_idle("t2", 20);
    chk("t2_addr", last_req_addr, 32'h40);
    chk("t2_we", 32'(last_req_we), 32'd0);
    chk("t2_rdata", if_rdata_o, 32'h00500093);
    chk("t2_pulses", 32'(if_pulses), 32'd1);
    chk("t2_req_cycles", 32'(req_cycles), 32'd2);

    // Simultaneous requests: data first
    clr_counts();
    ack_lat = 0; rd_val = 32'h11112222;
    dm_we = 0; dm_addr = 32'h100; dm_req = 1; dm_left = 1;
    if_addr = 32'h44; if_req = 1; if_left = 1;
    run_until_idle("t3", 30);
    chk_str("t3_order", glog, "DI");
    chk("t3_if_stall_at_dm_ready", 32'(stall_flag), 32'd1);

    // Starvation guard
    clr_counts();
    rd_val = 32'h33334444;
    dm_we = 0; dm_addr = 32'h300; dm_req = 1; dm_left = 4;
    if_addr = 32'h48; if_req = 1; if_left = 1;
    run_until_idle("t4", 60);
    chk_str("t4_order", glog, "DDDID");

    // Slow store
    clr_counts();
    ack_lat = 4; rd_val = 32'h55556666;
    dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; dm_req = 1; dm_left = 1;
    run_until_idle("t5", 30);
    chk("t5_stable", 32'(stable_cnt), 32'd5);
    chk("t5_pulses", 32'(dm_pulses), 32'd1);
    chk("t5_ack_to_ready", 32'(dm_rdy_cyc - ack_cyc), 32'd1);

    // Reset while a load is outstanding, then a late ack
    clr_counts();
    ack_lat = 10; rd_val = 32'h77778888;
    dm_we = 0; dm_addr = 32'h280; dm_req = 1; dm_left = 1;
    repeat (3) begin drive(); cycle(); end
    chk("t6_busy_before_rst", 32'(mem_req_o), 32'd1);
    rst = 1; dm_req = 0; dm_left = 0;
    cycle();
    rst = 0;
    chk("t6_mem_req_after_rst", 32'(mem_req_o), 32'd0);
    cycle();
    force_ack = 1;
    repeat (3) cycle();
    chk("t6_no_ready", 32'(dm_pulses), 32'd0);
    ack_lat = 1; rd_val = 32'h0000ABCD;
    if_addr = 32'h60; if_req = 1; if_left = 1;
    run_until_idle("t6", 20);
    chk("t6_if_pulses", 32'(if_pulses), 32'd1);
    chk("t6_if_rdata", if_rdata_o, 32'h0000ABCD);

    // Randomized soak
    rnd_mode = 1; lat_rand = 1; spur = 1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      drive();
      cycle();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
